// File: rtl/digit_scan_decoder_if.sv
//------------------------------------------------------------------------------
// digit_scan_decoder_if : control inputs and display outputs of digit_scan_decoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface digit_scan_decoder_if #(
  parameter int SEL_W = 3
);
  logic                  enable;
  logic                  mode;
  logic [SEL_W-1:0]      S;
  logic [2**SEL_W-1:0]   Y;
  logic [SEL_W-1:0]      idx;
  logic                  advance;
  logic                  frame;
  logic                  blank;

  modport master (
    output enable, mode, S,
    input  Y, idx, advance, frame, blank
  );

  modport slave (
    input  enable, mode, S,
    output Y, idx, advance, frame, blank
  );
endinterface

`default_nettype wire

// File: rtl/digit_scan_decoder.sv
//------------------------------------------------------------------------------
// digit_scan_decoder : registered one-hot decoder with direct and scanned modes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module digit_scan_decoder #(
  parameter int SEL_W        = 3,
  parameter int N_ACTIVE     = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 0,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  digit_scan_decoder_if.slave   bus
);

  localparam int Y_W  = 2**SEL_W;
  localparam int DW_W = $clog2(SCAN_DIV);

  localparam logic [Y_W-1:0]   c_y_off      = (ACTIVE_LOW != 0) ? {Y_W{1'b1}} : {Y_W{1'b0}};
  localparam logic [SEL_W-1:0] c_idx_last   = SEL_W'(N_ACTIVE - 1);
  localparam logic [DW_W-1:0]  c_dwell_last = DW_W'(SCAN_DIV - 1);

  function automatic logic [Y_W-1:0] decode(input logic [SEL_W-1:0] s);
    logic [Y_W-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  logic [Y_W-1:0]   r_y;
  logic [SEL_W-1:0] r_idx;
  logic [DW_W-1:0]  r_dwell;
  logic             r_mode;
  logic             r_advance;
  logic             r_frame;
  logic             r_blank;

  logic             w_step;
  logic             w_wrap;
  logic [DW_W-1:0]  w_next_dwell;
  logic [SEL_W-1:0] w_next_idx;
  logic             w_next_blank;
  logic             w_sel_ok;

  always_comb begin
    w_step       = (r_dwell == c_dwell_last);
    w_wrap       = w_step && (r_idx == c_idx_last);
    w_next_dwell = w_step ? '0 : r_dwell + 1'b1;
    w_next_idx   = w_wrap ? '0 : (w_step ? r_idx + 1'b1 : r_idx);
    w_next_blank = int'(w_next_dwell) < BLANK_CYCLES;
    w_sel_ok     = int'(bus.S) < N_ACTIVE;
  end

  // r_idx doubles as the scan index; every entry into scan mode restarts it at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y       <= c_y_off;
      r_idx     <= '0;
      r_dwell   <= '0;
      r_mode    <= 1'b0;
      r_advance <= 1'b0;
      r_frame   <= 1'b0;
      r_blank   <= 1'b0;
    end else begin
      r_mode <= bus.mode;
      if (!bus.mode) begin
        r_idx     <= bus.S;
        r_y       <= (bus.enable && w_sel_ok) ? decode(bus.S) : c_y_off;
        r_dwell   <= '0;
        r_advance <= 1'b0;
        r_frame   <= 1'b0;
        r_blank   <= 1'b0;
      end else if (!r_mode) begin
        r_idx     <= '0;
        r_dwell   <= '0;
        r_advance <= 1'b0;
        r_frame   <= 1'b0;
        r_blank   <= bus.enable && (BLANK_CYCLES > 0);
        r_y       <= (bus.enable && (BLANK_CYCLES == 0)) ? decode('0) : c_y_off;
      end else if (!bus.enable) begin
        r_y       <= c_y_off;
        r_advance <= 1'b0;
        r_frame   <= 1'b0;
        r_blank   <= 1'b0;
      end else begin
        r_dwell   <= w_next_dwell;
        r_idx     <= w_next_idx;
        r_advance <= w_step;
        r_frame   <= w_wrap;
        r_blank   <= w_next_blank;
        r_y       <= w_next_blank ? c_y_off : decode(w_next_idx);
      end
    end
  end

  assign bus.Y       = r_y;
  assign bus.idx     = r_idx;
  assign bus.advance = r_advance;
  assign bus.frame   = r_frame;
  assign bus.blank   = r_blank;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_decoder.sv
//------------------------------------------------------------------------------
// tb_digit_scan_decoder : two decoder configurations against a position-based model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_digit_scan_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digit_scan_decoder_if #(.SEL_W(3)) ifA();
  digit_scan_decoder_if #(.SEL_W(2)) ifB();

  digit_scan_decoder #(
    .SEL_W(3), .N_ACTIVE(6), .SCAN_DIV(5), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) dutA (.clk(clk), .reset(reset), .bus(ifA));

  digit_scan_decoder #(
    .SEL_W(2), .N_ACTIVE(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)
  ) dutB (.clk(clk), .reset(reset), .bus(ifB));

  int n_vec = 0;
  int n_err = 0;

  // configuration of each instance: index 0 = dutA, 1 = dutB
  int c_n[2]     = '{6, 4};
  int c_div[2]   = '{5, 4};
  int c_blank[2] = '{2, 1};
  int c_low[2]   = '{1, 0};
  int c_yw[2]    = '{8, 4};

  // scan position within a frame: digit = pos / div, dwell = pos % div
  int m_pos[2];
  bit m_smode[2];
  int e_y[2], e_idx[2], e_adv[2], e_frm[2], e_blk[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int y_of(input int k, input bit lit, input int i);
    int mask;
    int v;
    mask = (1 << c_yw[k]) - 1;
    v    = lit ? (1 << i) : 0;
    return (c_low[k] != 0) ? (~v & mask) : v;
  endfunction

  task automatic model_step(input int k, input bit rst, input bit en, input bit md, input int s);
    int d;
    if (rst) begin
      m_pos[k] = 0; m_smode[k] = 0;
      e_y[k] = y_of(k, 0, 0); e_idx[k] = 0; e_adv[k] = 0; e_frm[k] = 0; e_blk[k] = 0;
      return;
    end
    e_adv[k] = 0; e_frm[k] = 0; e_blk[k] = 0;
    if (!md) begin
      m_pos[k] = 0;
      e_idx[k] = s;
      e_y[k]   = y_of(k, en && (s < c_n[k]), s);
    end else if (!m_smode[k]) begin
      m_pos[k] = 0;
      e_idx[k] = 0;
      e_blk[k] = en && (c_blank[k] > 0);
      e_y[k]   = y_of(k, en && (c_blank[k] == 0), 0);
    end else if (!en) begin
      e_idx[k] = m_pos[k] / c_div[k];
      e_y[k]   = y_of(k, 0, 0);
    end else begin
      m_pos[k] = (m_pos[k] + 1) % (c_n[k] * c_div[k]);
      d        = m_pos[k] % c_div[k];
      e_idx[k] = m_pos[k] / c_div[k];
      e_adv[k] = (d == 0);
      e_frm[k] = (m_pos[k] == 0);
      e_blk[k] = (d < c_blank[k]);
      e_y[k]   = y_of(k, !(d < c_blank[k]), e_idx[k]);
    end
    m_smode[k] = md;
  endtask

  task automatic tick(input bit rst, input bit en, input bit md, input int sa, input int sb);
    logic [31:0] va;
    logic [31:0] vb;
    va = sa;
    vb = sb;
    reset      = rst;
    ifA.enable = en;  ifA.mode = md;  ifA.S = va[2:0];
    ifB.enable = en;  ifB.mode = md;  ifB.S = vb[1:0];
    @(posedge clk);
    model_step(0, rst, en, md, int'(va[2:0]));
    model_step(1, rst, en, md, int'(vb[1:0]));
    #1;
    check_val("A.Y",       32'(ifA.Y),       e_y[0]);
    check_val("A.idx",     32'(ifA.idx),     e_idx[0]);
    check_val("A.advance", 32'(ifA.advance), e_adv[0]);
    check_val("A.frame",   32'(ifA.frame),   e_frm[0]);
    check_val("A.blank",   32'(ifA.blank),   e_blk[0]);
    check_val("B.Y",       32'(ifB.Y),       e_y[1]);
    check_val("B.idx",     32'(ifB.idx),     e_idx[1]);
    check_val("B.advance", 32'(ifB.advance), e_adv[1]);
    check_val("B.frame",   32'(ifB.frame),   e_frm[1]);
    check_val("B.blank",   32'(ifB.blank),   e_blk[1]);
  endtask

  initial begin
    int kind;
    int len;
    bit en;

    repeat (3) tick(1, 0, 0, 0, 0);
    check_val("A.Y.reset", 32'(ifA.Y), 32'hFF);

    tick(0, 1, 0, 3, 3);
    check_val("A.Y.dir3", 32'(ifA.Y), 32'hF7);
    tick(0, 1, 0, 6, 1);
    tick(0, 1, 0, 7, 2);
    check_val("A.Y.oor7", 32'(ifA.Y), 32'hFF);
    tick(0, 1, 0, 5, 0);
    check_val("A.Y.dir5", 32'(ifA.Y), 32'hDF);
    tick(0, 0, 0, 3, 3);
    check_val("A.Y.en0", 32'(ifA.Y), 32'hFF);

    // enter scan, then reach B at digit 2 / dwell 2 and drop enable
    for (int i = 0; i < 11; i++) tick(0, 1, 1, 0, 0);
    check_val("B.idx.pre_drop", 32'(ifB.idx), 32'd2);
    repeat (5) tick(0, 0, 1, 0, 0);
    check_val("B.Y.drop", 32'(ifB.Y), 32'h0);
    tick(0, 1, 1, 0, 0);
    check_val("B.Y.resume", 32'(ifB.Y), 32'h4);
    tick(0, 1, 1, 0, 0);
    check_val("B.adv.resume", 32'(ifB.advance), 32'd1);
    tick(1, 1, 1, 0, 0);
    check_val("B.idx.reset", 32'(ifB.idx), 32'd0);

    for (int i = 0; i < 40; i++) tick(0, 1, 1, 0, 0);

    for (int seg = 0; seg < 80; seg++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        case (kind)
          0:       tick(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
          1, 2:    tick(0, $urandom_range(0, 3) != 0, 0, $urandom_range(0, 7), $urandom_range(0, 3));
          9:       tick(0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 3));
          default: begin
            en = ($urandom_range(0, 7) != 0);
            tick(0, en, 1, $urandom_range(0, 7), $urandom_range(0, 3));
          end
        endcase
        if (kind == 0 && c >= 1) break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
